// File: rtl/trigger_sequencer.sv
// trigger_sequencer: acquisition trigger controller for the scope capture path.
// Accepts a single-cycle trigger from the selected source, then sequences the
// trigger delay, the acquisition window, the holdoff and the repeat count.
// Ports:
//   aclk, aresetn             clock and synchronous active-low reset
//   cfg_source                trigger source select (0 = ext_trigger, 1 = sw_trigger)
//   cfg_delay/length/holdoff  timing config, latched on an accepted arm
//   cfg_repeats               acquisitions per arm (0 = unlimited), latched on arm
//   arm, abort                single-cycle control requests
//   ext_trigger, sw_trigger   single-cycle trigger pulses
//   acq_active, acq_start     acquisition window and its first-cycle strobe
//   armed, busy, done         status flags (done is sticky until the next arm)
//   trig_count                completed acquisitions since the last arm
//   missed_triggers           triggers dropped while running, saturating
module trigger_sequencer #(
    parameter int unsigned DELAY_WIDTH = 32,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   cfg_source,
    input  logic [DELAY_WIDTH-1:0] cfg_delay,
    input  logic [DELAY_WIDTH-1:0] cfg_length,
    input  logic [DELAY_WIDTH-1:0] cfg_holdoff,
    input  logic [COUNT_WIDTH-1:0] cfg_repeats,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   ext_trigger,
    input  logic                   sw_trigger,
    output logic                   acq_active,
    output logic                   acq_start,
    output logic                   armed,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] trig_count,
    output logic [COUNT_WIDTH-1:0] missed_triggers
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_DELAY   = 3'd2;
    localparam logic [2:0] ST_ACQUIRE = 3'd3;
    localparam logic [2:0] ST_HOLDOFF = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
    logic                   source_q, source_d;
    logic [DELAY_WIDTH-1:0] delay_q, delay_d;
    logic [DELAY_WIDTH-1:0] length_q, length_d;
    logic [DELAY_WIDTH-1:0] holdoff_q, holdoff_d;
    logic [COUNT_WIDTH-1:0] repeats_q, repeats_d;
    logic [COUNT_WIDTH-1:0] trig_count_q, trig_count_d;
    logic [COUNT_WIDTH-1:0] missed_q, missed_d;
    logic                   done_q, done_d;
    logic                   acq_start_q, acq_start_d;

    logic                   trig;
    logic [COUNT_WIDTH-1:0] count_inc;
    logic [COUNT_WIDTH-1:0] missed_inc;

    // State and datapath registers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            source_q     <= 1'b0;
            delay_q      <= '0;
            length_q     <= '0;
            holdoff_q    <= '0;
            repeats_q    <= '0;
            trig_count_q <= '0;
            missed_q     <= '0;
            done_q       <= 1'b0;
            acq_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            source_q     <= source_d;
            delay_q      <= delay_d;
            length_q     <= length_d;
            holdoff_q    <= holdoff_d;
            repeats_q    <= repeats_d;
            trig_count_q <= trig_count_d;
            missed_q     <= missed_d;
            done_q       <= done_d;
            acq_start_q  <= acq_start_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        source_d     = source_q;
        delay_d      = delay_q;
        length_d     = length_q;
        holdoff_d    = holdoff_q;
        repeats_d    = repeats_q;
        trig_count_d = trig_count_q;
        missed_d     = missed_q;
        done_d       = done_q;
        acq_start_d  = 1'b0;

        trig       = source_q ? sw_trigger : ext_trigger;
        count_inc  = trig_count_q + COUNT_WIDTH'(1);
        missed_inc = (&missed_q) ? missed_q : missed_q + COUNT_WIDTH'(1);

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d      = ST_ARMED;
                        source_d     = cfg_source;
                        delay_d      = cfg_delay;
                        // Length 0 behaves as a one-cycle window
                        length_d     = (cfg_length == '0) ? DELAY_WIDTH'(1) : cfg_length;
                        holdoff_d    = cfg_holdoff;
                        repeats_d    = cfg_repeats;
                        trig_count_d = '0;
                        missed_d     = '0;
                        done_d       = 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (trig) begin
                        if (delay_q == '0) begin
                            state_d     = ST_ACQUIRE;
                            cnt_d       = length_q - DELAY_WIDTH'(1);
                            acq_start_d = 1'b1;
                        end else begin
                            state_d = ST_DELAY;
                            cnt_d   = delay_q - DELAY_WIDTH'(1);
                        end
                    end
                end
                ST_DELAY: begin
                    if (trig) missed_d = missed_inc;
                    if (cnt_q == '0) begin
                        state_d     = ST_ACQUIRE;
                        cnt_d       = length_q - DELAY_WIDTH'(1);
                        acq_start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - DELAY_WIDTH'(1);
                    end
                end
                ST_ACQUIRE: begin
                    if (trig) missed_d = missed_inc;
                    if (cnt_q == '0) begin
                        trig_count_d = count_inc;
                        if ((repeats_q != '0) && (count_inc == repeats_q)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else if (holdoff_q == '0) begin
                            state_d = ST_ARMED;
                        end else begin
                            state_d = ST_HOLDOFF;
                            cnt_d   = holdoff_q - DELAY_WIDTH'(1);
                        end
                    end else begin
                        cnt_d = cnt_q - DELAY_WIDTH'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (trig) missed_d = missed_inc;
                    if (cnt_q == '0) begin
                        state_d = ST_ARMED;
                    end else begin
                        cnt_d = cnt_q - DELAY_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers or state decode
    assign acq_active      = (state_q == ST_ACQUIRE);
    assign acq_start       = acq_start_q;
    assign armed           = (state_q == ST_ARMED);
    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign trig_count      = trig_count_q;
    assign missed_triggers = missed_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Bench for trigger_sequencer: directed scenarios plus random stimulus, every
// cycle compared against a timestamp-based reference model.
module tb_trigger_sequencer;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          cfg_source;
    logic [DW-1:0] cfg_delay, cfg_length, cfg_holdoff;
    logic [CW-1:0] cfg_repeats;
    logic          arm, abort, ext_trigger, sw_trigger;
    logic          acq_active, acq_start, armed, busy, done;
    logic [CW-1:0] trig_count, missed_triggers;

    trigger_sequencer #(.DELAY_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_source(cfg_source), .cfg_delay(cfg_delay), .cfg_length(cfg_length),
        .cfg_holdoff(cfg_holdoff), .cfg_repeats(cfg_repeats),
        .arm(arm), .abort(abort), .ext_trigger(ext_trigger), .sw_trigger(sw_trigger),
        .acq_active(acq_active), .acq_start(acq_start), .armed(armed), .busy(busy),
        .done(done), .trig_count(trig_count), .missed_triggers(missed_triggers)
    );

    always #5 aclk = ~aclk;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc_n    = 0;
    longint first_start;
    int     act_cnt;

    // Reference model: 0 idle, 1 waiting for trigger, 2 running a scheduled shot
    int     m_mode = 0;
    longint m_start, m_end, m_rearm;
    logic   m_src = 1'b0;
    longint m_delay = 0, m_len = 1, m_hold = 0;
    int     m_rep = 0, m_cnt = 0, m_miss = 0;
    logic   m_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_n, obs, exp);
        end
    endtask

    task automatic model_step(input logic a, input logic ab, input logic e, input logic s,
                              input logic r);
        logic t;
        t = m_src ? s : e;
        if (!r) begin
            m_mode = 0; m_done = 1'b0; m_cnt = 0; m_miss = 0;
            m_src = 1'b0; m_delay = 0; m_len = 1; m_hold = 0; m_rep = 0;
        end else if (ab) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (a) begin
                m_src   = cfg_source;
                m_delay = longint'(cfg_delay);
                m_len   = (cfg_length == '0) ? 1 : longint'(cfg_length);
                m_hold  = longint'(cfg_holdoff);
                m_rep   = int'(cfg_repeats);
                m_done  = 1'b0; m_cnt = 0; m_miss = 0;
                m_mode  = 1;
            end
        end else if (m_mode == 1) begin
            if (t) begin
                m_start = cyc_n + 1 + m_delay;
                m_end   = m_start + m_len - 1;
                m_rearm = m_end + m_hold + 1;
                m_mode  = 2;
            end
        end else begin
            if (t) m_miss = (m_miss == 65535) ? 65535 : m_miss + 1;
            if (cyc_n == m_end) begin
                m_cnt = (m_cnt + 1) % 65536;
                if (m_rep != 0 && m_cnt == m_rep) begin
                    m_done = 1'b1;
                    m_mode = 0;
                end
            end
            if (m_mode == 2 && cyc_n + 1 == m_rearm) m_mode = 1;
        end
    endtask

    // One clock cycle: compare outputs, drive this cycle's inputs, advance the model
    task automatic cyc(input logic a, input logic ab, input logic e, input logic s,
                       input logic r);
        logic e_act, e_start;
        @(negedge aclk);
        e_act   = (m_mode == 2) && (cyc_n >= m_start) && (cyc_n <= m_end);
        e_start = (m_mode == 2) && (cyc_n == m_start);
        check("acq_active", 32'(acq_active), 32'(e_act));
        check("acq_start", 32'(acq_start), 32'(e_start));
        check("armed", 32'(armed), 32'(m_mode == 1));
        check("busy", 32'(busy), 32'(m_mode != 0));
        check("done", 32'(done), 32'(m_done));
        check("trig_count", 32'(trig_count), 32'(m_cnt));
        check("missed", 32'(missed_triggers), 32'(m_miss));
        if (acq_start && first_start < 0) first_start = cyc_n;
        if (acq_active) act_cnt++;
        arm = a; abort = ab; ext_trigger = e; sw_trigger = s; aresetn = r;
        model_step(a, ab, e, s, r);
        cyc_n++;
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic set_cfg(input logic src, input int d, input int l, input int h, input int rp);
        cfg_source  = src;
        cfg_delay   = DW'(d);
        cfg_length  = DW'(l);
        cfg_holdoff = DW'(h);
        cfg_repeats = CW'(rp);
    endtask

    initial begin
        longint base;
        aresetn = 1'b0; arm = 1'b0; abort = 1'b0; ext_trigger = 1'b0; sw_trigger = 1'b0;
        set_cfg(1'b0, 0, 0, 0, 0);
        repeat (2) @(posedge aclk);
        #1;

        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Single shot: delay 3, length 5
        set_cfg(1'b0, 3, 5, 0, 1);
        base = cyc_n; first_start = -1; act_cnt = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(9);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(12);
        check("ss_start_cycle", 32'(first_start - base), 32'd14);
        check("ss_window_len", 32'(act_cnt), 32'd5);
        check("ss_done", 32'(done), 32'd1);
        check("ss_count", 32'(trig_count), 32'd1);

        // Zero delay and zero length
        set_cfg(1'b0, 0, 0, 0, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        base = cyc_n; first_start = -1; act_cnt = 0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(4);
        check("zero_start_cycle", 32'(first_start - base), 32'd1);
        check("zero_window_len", 32'(act_cnt), 32'd1);

        // Repeats with holdoff, trigger held high
        set_cfg(1'b0, 0, 2, 4, 3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        base = cyc_n; first_start = -1; act_cnt = 0;
        for (int i = 0; i < 25; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2);
        check("rep_first_start", 32'(first_start - base), 32'd1);
        check("rep_windows", 32'(act_cnt), 32'd6);
        check("rep_missed", 32'(missed_triggers), 32'd14);
        check("rep_count", 32'(trig_count), 32'd3);
        check("rep_done", 32'(done), 32'd1);

        // Source select: ext ignored when software is selected
        set_cfg(1'b1, 0, 3, 0, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        act_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            idle(1);
        end
        check("src_ext_ignored", 32'(act_cnt), 32'd0);
        check("src_armed", 32'(armed), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(5);
        check("src_sw_window", 32'(act_cnt), 32'd3);
        check("src_missed", 32'(missed_triggers), 32'd0);

        // Abort on the 20th acquisition cycle, then a full run
        set_cfg(1'b0, 0, 100, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(19);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("abort_active", 32'(acq_active), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_count", 32'(trig_count), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        act_cnt = 0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(105);
        check("abort_rerun_len", 32'(act_cnt), 32'd100);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Arm during DELAY ignored; config change while armed ignored; reset mid-window
        set_cfg(1'b0, 10, 3, 0, 2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(3);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rob_arm_missed_kept", 32'(missed_triggers), 32'd1);
        idle(12);
        check("rob_count_after_1", 32'(trig_count), 32'd1);
        cfg_delay = DW'(0);
        base = cyc_n; first_start = -1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(11);
        check("rob_old_delay", 32'(first_start - base), 32'd11);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_active", 32'(acq_active), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_armed", 32'(armed), 32'd0);
        check("rst_start", 32'(acq_start), 32'd0);
        check("rst_count", 32'(trig_count), 32'd0);
        check("rst_missed", 32'(missed_triggers), 32'd0);
        idle(2);

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            logic a, ab, e, s, r;
            if ($urandom_range(0, 39) == 0)
                set_cfg(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                        int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                        int'($urandom_range(0, 4)));
            a  = ($urandom_range(0, 7) == 0);
            ab = ($urandom_range(0, 59) == 0);
            r  = ($urandom_range(0, 299) != 0);
            e  = ($urandom_range(0, 3) == 0);
            s  = ($urandom_range(0, 3) == 0);
            cyc(a, ab, e, s, r);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Missed-trigger saturation over a long delay
        set_cfg(1'b0, 65600, 1, 0, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 65605; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("sat_missed", 32'(missed_triggers), 32'h0000_FFFF);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
